// File: rtl/gf256_pkg.sv
// Shared GF(2^8) types and constants for the Horner evaluator and its multiplier.
// Field polynomial is x^8+x^4+x^3+x^2+1, the usual Reed-Solomon choice.
package gf256_pkg;

    localparam logic [8:0] GF256_FIELD_POLY = 9'h11D;

    typedef logic [7:0] gf256_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    // Multiply by x and fold bit 8 back using the field polynomial.
    function automatic gf256_t gf256_xtime(input gf256_t v);
        return {v[6:0], 1'b0} ^ (v[7] ? GF256_FIELD_POLY[7:0] : 8'h00);
    endfunction

endpackage

// File: rtl/gf256_poly_mult_mastrovito.sv
// Combinational GF(2^8) multiplier in Mastrovito form: column i of the product
// matrix is a*x^i reduced mod the field polynomial, selected by bit i of b.
module gf256_poly_mult_mastrovito
    import gf256_pkg::*;
(
    input  gf256_t a,
    input  gf256_t b,
    output gf256_t p
);

    gf256_t col;

    always_comb begin
        col = a;
        p   = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ col;
            end
            col = gf256_xtime(col);
        end
    end

endmodule

// File: rtl/gf256_horner_eval.sv
// Sequential GF(2^8) polynomial evaluator: acc <- acc*x ^ coef, one coefficient
// per cycle, highest degree first, with a result handshake at the end.
module gf256_horner_eval
    import gf256_pkg::*;
#(
    parameter  int MAX_LEN = 255,
    localparam int CW      = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [7:0]    eval_point,
    input  logic          sym_valid,
    output logic          sym_ready,
    input  logic [7:0]    sym_data,
    input  logic          sym_last,
    output logic          result_valid,
    input  logic          result_ready,
    output logic [7:0]    result,
    output logic          overflow,
    output logic [CW-1:0] sym_count,
    output logic          busy
);

    localparam logic [CW-1:0] LAST_IDX = CW'(MAX_LEN - 1);

    state_t        state_q, state_d;
    gf256_t        acc_q, acc_d;
    gf256_t        x_q, x_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    gf256_t        product;

    gf256_poly_mult_mastrovito u_mult (
        .a (acc_q),
        .b (x_q),
        .p (product)
    );

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        x_d          = x_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        sym_ready    = 1'b0;
        result_valid = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d        = eval_point;
                    acc_d      = '0;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    state_d    = ACCUM;
                end
            end
            ACCUM: begin
                sym_ready = 1'b1;
                if (sym_valid) begin
                    acc_d   = product ^ sym_data;
                    count_d = count_q + CW'(1);
                    // sym_last wins over the length limit on the final slot.
                    if (sym_last) begin
                        overflow_d = 1'b0;
                        state_d    = DONE;
                    end else if (count_q == LAST_IDX) begin
                        overflow_d = 1'b1;
                        state_d    = DONE;
                    end
                end
            end
            DONE: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            x_q        <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            x_q        <= x_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign result    = acc_q;
    assign overflow  = overflow_q;
    assign sym_count = count_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_gf256_horner_eval.sv
// Self-checking bench for gf256_horner_eval: a default-length instance and a
// MAX_LEN=4 instance, checked against a carry-less-multiply Horner model.
module tb_gf256_horner_eval;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [7:0] eval_point;
    logic       sym_valid;
    logic [7:0] sym_data;
    logic       sym_last;
    logic       result_ready;
    logic       use4;

    logic       m_start, m_valid, m_rready;
    logic       f_start, f_valid, f_rready;
    logic       m_sym_ready, m_result_valid, m_overflow, m_busy;
    logic       f_sym_ready, f_result_valid, f_overflow, f_busy;
    logic [7:0] m_result, f_result;
    logic [7:0] m_count;
    logic [2:0] f_count;

    logic       obs_ready, obs_rv, obs_ovf, obs_busy;
    logic [7:0] obs_result;
    logic [8:0] obs_count;

    int errors = 0;
    int checks = 0;
    logic [7:0] coefs[$];

    assign m_start  = start & ~use4;
    assign m_valid  = sym_valid & ~use4;
    assign m_rready = result_ready & ~use4;
    assign f_start  = start & use4;
    assign f_valid  = sym_valid & use4;
    assign f_rready = result_ready & use4;

    assign obs_ready  = use4 ? f_sym_ready    : m_sym_ready;
    assign obs_rv     = use4 ? f_result_valid : m_result_valid;
    assign obs_ovf    = use4 ? f_overflow     : m_overflow;
    assign obs_busy   = use4 ? f_busy         : m_busy;
    assign obs_result = use4 ? f_result       : m_result;
    assign obs_count  = use4 ? {6'd0, f_count} : {1'b0, m_count};

    gf256_horner_eval #(.MAX_LEN(255)) dut (
        .clk(clk), .reset_n(reset_n), .start(m_start), .eval_point(eval_point),
        .sym_valid(m_valid), .sym_ready(m_sym_ready), .sym_data(sym_data),
        .sym_last(sym_last), .result_valid(m_result_valid), .result_ready(m_rready),
        .result(m_result), .overflow(m_overflow), .sym_count(m_count), .busy(m_busy)
    );

    gf256_horner_eval #(.MAX_LEN(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(f_start), .eval_point(eval_point),
        .sym_valid(f_valid), .sym_ready(f_sym_ready), .sym_data(sym_data),
        .sym_last(sym_last), .result_valid(f_result_valid), .result_ready(f_rready),
        .result(f_result), .overflow(f_overflow), .sym_count(f_count), .busy(f_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Schoolbook carry-less product followed by long division by 0x11D.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] prod;
        prod = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) prod = prod ^ (15'(a) << i);
        for (int k = 14; k >= 8; k--)
            if (prod[k]) prod = prod ^ (15'(9'h11D) << (k - 8));
        return prod[7:0];
    endfunction

    function automatic logic [7:0] ref_eval(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h00;
        foreach (coefs[i]) r = ref_mul(r, x) ^ coefs[i];
        return r;
    endfunction

    function automatic logic [7:0] rand_point();
        case ($urandom_range(3))
            0:       return 8'h00;
            1:       return 8'h01;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic do_start(input logic [7:0] x);
        start      = 1'b1;
        eval_point = x;
        @(negedge clk);
        start      = 1'b0;
        eval_point = 8'($urandom);
    endtask

    task automatic feed(input int stall_pct, input bit mark_last, output bit timed_out);
        int idx;
        int budget;
        bit hs;
        idx = 0;
        budget = 0;
        timed_out = 1'b0;
        while (idx < coefs.size()) begin
            if (budget > 40 * coefs.size() + 20) begin
                timed_out = 1'b1;
                break;
            end
            budget++;
            sym_valid = ($urandom_range(99) >= stall_pct);
            sym_data  = sym_valid ? coefs[idx] : 8'($urandom);
            sym_last  = sym_valid && mark_last && (idx == coefs.size() - 1);
            hs = sym_valid && obs_ready;
            @(negedge clk);
            if (hs) idx++;
        end
        sym_valid = 1'b0;
        sym_last  = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (obs_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_sym_ready: got %b expected 0", obs_ready); end
        checks++; if (obs_rv !== 1'b0) begin errors++; $display("[TB] FAIL reset_result_valid: got %b expected 0", obs_rv); end
        checks++; if (obs_result !== 8'h00) begin errors++; $display("[TB] FAIL reset_result: got %h expected 00", obs_result); end
        checks++; if (obs_ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", obs_ovf); end
        checks++; if (obs_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", obs_busy); end
        checks++; if (obs_count !== 9'd0) begin errors++; $display("[TB] FAIL reset_sym_count: got %0d expected 0", obs_count); end
        checks++; if (f_busy !== 1'b0 || f_count !== 3'd0) begin errors++; $display("[TB] FAIL reset_dut4: got busy=%b count=%0d expected 0/0", f_busy, f_count); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [7:0] x;
        logic [7:0] exp_r;
        bit to;
        for (int c = 0; c < 4; c++) begin
            case (c)
                0: begin x = 8'h02; coefs = '{8'h01, 8'h00}; exp_r = 8'h02; end
                1: begin x = 8'h02; coefs = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; exp_r = 8'h1D; end
                2: begin x = 8'h01; coefs = '{8'h12, 8'h34, 8'h56}; exp_r = 8'h70; end
                default: begin x = 8'h00; coefs = '{8'h12, 8'h34, 8'h56}; exp_r = 8'h56; end
            endcase
            do_start(x);
            checks++; if (obs_ready !== 1'b1) begin errors++; $display("[TB] FAIL dir%0d_ready_after_start: got %b expected 1", c, obs_ready); end
            feed(0, 1'b1, to);
            checks++; if (to) begin errors++; $display("[TB] FAIL dir%0d_feed_timeout: got timeout expected completion", c); end
            checks++; if (obs_rv !== 1'b1) begin errors++; $display("[TB] FAIL dir%0d_result_valid: got %b expected 1", c, obs_rv); end
            checks++; if (obs_result !== exp_r) begin errors++; $display("[TB] FAIL dir%0d_result: got %h expected %h", c, obs_result, exp_r); end
            checks++; if (obs_ovf !== 1'b0) begin errors++; $display("[TB] FAIL dir%0d_overflow: got %b expected 0", c, obs_ovf); end
            checks++; if (obs_count !== 9'(coefs.size())) begin errors++; $display("[TB] FAIL dir%0d_sym_count: got %0d expected %0d", c, obs_count, coefs.size()); end
            result_ready = 1'b1;
            @(negedge clk);
            result_ready = 1'b0;
            checks++; if (obs_busy !== 1'b0) begin errors++; $display("[TB] FAIL dir%0d_busy_after_consume: got %b expected 0", c, obs_busy); end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] x;
        logic [7:0] exp_r;
        bit to;
        use4 = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            coefs.delete();
            case (c)
                0: begin x = 8'h03; coefs = '{8'h01, 8'h01, 8'h01, 8'h01}; end
                1: begin x = 8'($urandom); repeat (4) coefs.push_back(8'($urandom)); end
                default: begin x = 8'($urandom); repeat (3) coefs.push_back(8'($urandom)); end
            endcase
            exp_r = ref_eval(x);
            do_start(x);
            feed(0, c != 0, to);
            checks++; if (to) begin errors++; $display("[TB] FAIL ovf%0d_feed_timeout: got timeout expected completion", c); end
            checks++; if (obs_rv !== 1'b1) begin errors++; $display("[TB] FAIL ovf%0d_result_valid: got %b expected 1", c, obs_rv); end
            checks++; if (obs_ready !== 1'b0) begin errors++; $display("[TB] FAIL ovf%0d_sym_ready: got %b expected 0", c, obs_ready); end
            checks++; if (obs_result !== exp_r) begin errors++; $display("[TB] FAIL ovf%0d_result: got %h expected %h", c, obs_result, exp_r); end
            checks++; if (obs_ovf !== (c == 0)) begin errors++; $display("[TB] FAIL ovf%0d_overflow: got %b expected %b", c, obs_ovf, c == 0); end
            checks++; if (obs_count !== 9'(coefs.size())) begin errors++; $display("[TB] FAIL ovf%0d_sym_count: got %0d expected %0d", c, obs_count, coefs.size()); end
            sym_valid = 1'b1;
            sym_data  = 8'hA5;
            @(negedge clk);
            sym_valid = 1'b0;
            checks++; if (obs_count !== 9'(coefs.size()) || obs_result !== exp_r) begin errors++; $display("[TB] FAIL ovf%0d_extra_symbol_ignored: got count=%0d result=%h expected %0d/%h", c, obs_count, obs_result, coefs.size(), exp_r); end
            result_ready = 1'b1;
            @(negedge clk);
            result_ready = 1'b0;
        end
        use4 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [7:0] x;
        logic [7:0] exp_r;
        bit to;
        for (int n = 0; n < 15; n++) begin
            coefs.delete();
            x = rand_point();
            repeat ($urandom_range(24, 1)) coefs.push_back(8'($urandom));
            exp_r = ref_eval(x);
            do_start(x);
            feed(40, 1'b1, to);
            checks++; if (to) begin errors++; $display("[TB] FAIL bp%0d_feed_timeout: got timeout expected completion", n); end
            checks++; if (obs_result !== exp_r) begin errors++; $display("[TB] FAIL bp%0d_result: got %h expected %h (x=%h len=%0d)", n, obs_result, exp_r, x, coefs.size()); end
            checks++; if (obs_count !== 9'(coefs.size()) || obs_ovf !== 1'b0) begin errors++; $display("[TB] FAIL bp%0d_count_ovf: got %0d/%b expected %0d/0", n, obs_count, obs_ovf, coefs.size()); end
            for (int k = 0; k < 5; k++) begin
                start      = 1'b1;
                eval_point = 8'($urandom);
                @(negedge clk);
                checks++; if (obs_rv !== 1'b1 || obs_result !== exp_r || obs_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp%0d_hold%0d: got rv=%b result=%h ready=%b expected 1/%h/0", n, k, obs_rv, obs_result, obs_ready, exp_r); end
            end
            result_ready = 1'b1;
            @(negedge clk);
            result_ready = 1'b0;
            start        = 1'b0;
            checks++; if (obs_busy !== 1'b0) begin errors++; $display("[TB] FAIL bp%0d_start_in_done_ignored: got busy=%b expected 0", n, obs_busy); end
            checks++; if (obs_result !== exp_r || obs_count !== 9'(coefs.size())) begin errors++; $display("[TB] FAIL bp%0d_idle_stable: got %h/%0d expected %h/%0d", n, obs_result, obs_count, exp_r, coefs.size()); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] x;
        logic [7:0] exp_r;
        logic [7:0] got;
        int cycles;
        int idx;
        bit hs;
        bit to;
        coefs.delete();
        repeat (6) coefs.push_back(8'($urandom));
        x = 8'($urandom);
        exp_r = ref_eval(x);
        got = 8'h00;
        idx = 0;
        result_ready = 1'b1;
        start = 1'b1;
        eval_point = x;
        @(negedge clk);
        start = 1'b0;
        cycles = 1;
        while (obs_busy && cycles < 100) begin
            if (obs_rv) got = obs_result;
            sym_valid = (idx < coefs.size());
            sym_data  = sym_valid ? coefs[idx] : 8'h00;
            sym_last  = sym_valid && (idx == coefs.size() - 1);
            hs = sym_valid && obs_ready;
            @(negedge clk);
            cycles++;
            if (hs) idx++;
        end
        sym_valid = 1'b0;
        sym_last = 1'b0;
        result_ready = 1'b0;
        checks++; if (cycles != coefs.size() + 2) begin errors++; $display("[TB] FAIL b2b_cycle_count: got %0d expected %0d", cycles, coefs.size() + 2); end
        checks++; if (got !== exp_r) begin errors++; $display("[TB] FAIL b2b_first_result: got %h expected %h", got, exp_r); end
        coefs.delete();
        repeat (5) coefs.push_back(8'($urandom));
        x = rand_point();
        exp_r = ref_eval(x);
        do_start(x);
        checks++; if (obs_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_restart_ready: got %b expected 1", obs_ready); end
        feed(0, 1'b1, to);
        checks++; if (to || obs_result !== exp_r) begin errors++; $display("[TB] FAIL b2b_second_result: got %h timeout=%b expected %h", obs_result, to, exp_r); end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] x;
        logic [7:0] exp_r;
        bit to;
        coefs = '{8'h5A, 8'hC3, 8'h77};
        do_start(8'h9B);
        feed(0, 1'b0, to);
        reset_n   = 1'b0;
        sym_valid = 1'b1;
        sym_data  = 8'hFF;
        @(negedge clk);
        checks++; if (obs_busy !== 1'b0 || obs_ready !== 1'b0 || obs_rv !== 1'b0) begin errors++; $display("[TB] FAIL midreset_ctrl: got busy=%b ready=%b rv=%b expected 0/0/0", obs_busy, obs_ready, obs_rv); end
        checks++; if (obs_result !== 8'h00 || obs_ovf !== 1'b0 || obs_count !== 9'd0) begin errors++; $display("[TB] FAIL midreset_data: got result=%h ovf=%b count=%0d expected 00/0/0", obs_result, obs_ovf, obs_count); end
        reset_n   = 1'b1;
        sym_valid = 1'b0;
        @(negedge clk);
        coefs.delete();
        repeat (7) coefs.push_back(8'($urandom));
        x = 8'($urandom);
        exp_r = ref_eval(x);
        do_start(x);
        feed(25, 1'b1, to);
        checks++; if (to || obs_result !== exp_r || obs_count !== 9'd7) begin errors++; $display("[TB] FAIL midreset_fresh_eval: got %h count=%0d timeout=%b expected %h/7", obs_result, obs_count, to, exp_r); end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b0;
        start        = 1'b0;
        eval_point   = 8'h00;
        sym_valid    = 1'b0;
        sym_data     = 8'h00;
        sym_last     = 1'b0;
        result_ready = 1'b0;
        use4         = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
